// File: rtl/pwm_duty_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_duty_ctrl_if
// Description : Button/mode inputs and duty/status outputs of pwm_duty_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm_duty_ctrl_if;
  logic       btn_up;
  logic       btn_dn;
  logic       mode;
  logic [3:0] duty;
  logic       step_pulse;
  logic       at_min;
  logic       at_max;
  logic       ramp_active;

  modport master (
    output btn_up, btn_dn, mode,
    input  duty, step_pulse, at_min, at_max, ramp_active
  );

  modport slave (
    input  btn_up, btn_dn, mode,
    output duty, step_pulse, at_min, at_max, ramp_active
  );
endinterface
`default_nettype wire

// File: rtl/pwm_duty_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pwm_duty_ctrl
// Description : Debounced up/down buttons step a saturating 4-bit PWM duty;
//               optional auto-ramp enabled by macro PWM_DUTY_CTRL_RAMP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_duty_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RAMP_DIV        = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  pwm_duty_ctrl_if.slave  bus
);

  localparam int                c_db_w    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_db_w-1:0] c_db_one  = c_db_w'(1);

  localparam logic [1:0] c_st_manual  = 2'd0;
`ifdef PWM_DUTY_CTRL_RAMP_EN
  localparam logic [1:0] c_st_ramp_up = 2'd1;
  localparam logic [1:0] c_st_ramp_dn = 2'd2;

  localparam int                 c_pre_w    = $clog2(RAMP_DIV + 1);
  localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(RAMP_DIV - 1);
  localparam logic [c_pre_w-1:0] c_pre_one  = c_pre_w'(1);

  logic [c_pre_w-1:0] r_presc;
  logic [c_pre_w-1:0] w_presc_nxt;
  logic               w_tick;
`endif

  // Bit 0 carries the up button, bit 1 the down button.
  logic [1:0]        w_raw;
  logic [1:0]        r_sync1;
  logic [1:0]        r_sync2;
  logic [1:0]        r_deb;
  logic [1:0]        r_deb_d;
  logic [c_db_w-1:0] r_db_cnt [2];
  logic [1:0]        w_press;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [3:0] r_duty;
  logic [3:0] w_duty_nxt;
  logic       r_step;

  assign w_raw   = {bus.btn_dn, bus.btn_up};
  assign w_press = r_deb & ~r_deb_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          if (r_db_cnt[i] == c_db_last) begin
            r_deb[i]    <= ~r_deb[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + c_db_one;
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

`ifdef PWM_DUTY_CTRL_RAMP_EN
  assign w_tick = (r_presc == c_pre_last);
`endif

  // State register, duty register and the strobe marking a duty change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_manual;
      r_duty  <= 4'd0;
      r_step  <= 1'b0;
`ifdef PWM_DUTY_CTRL_RAMP_EN
      r_presc <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_duty  <= w_duty_nxt;
      r_step  <= (w_duty_nxt != r_duty);
`ifdef PWM_DUTY_CTRL_RAMP_EN
      r_presc <= w_presc_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
`ifdef PWM_DUTY_CTRL_RAMP_EN
      c_st_manual:
        if (bus.mode) w_state_nxt = (r_duty == 4'd15) ? c_st_ramp_dn : c_st_ramp_up;
      c_st_ramp_up:
        if (!bus.mode)                    w_state_nxt = c_st_manual;
        else if (w_tick && r_duty >= 4'd14) w_state_nxt = c_st_ramp_dn;
      c_st_ramp_dn:
        if (!bus.mode)                    w_state_nxt = c_st_manual;
        else if (w_tick && r_duty <= 4'd1)  w_state_nxt = c_st_ramp_up;
`else
      c_st_manual: w_state_nxt = c_st_manual;
`endif
      default: w_state_nxt = c_st_manual;
    endcase
  end

  always_comb begin
    w_duty_nxt = r_duty;
`ifdef PWM_DUTY_CTRL_RAMP_EN
    w_presc_nxt = r_presc;
`endif
    case (r_state)
      c_st_manual: begin
        if (w_press[0] && !w_press[1] && r_duty != 4'd15)
          w_duty_nxt = r_duty + 4'd1;
        else if (w_press[1] && !w_press[0] && r_duty != 4'd0)
          w_duty_nxt = r_duty - 4'd1;
`ifdef PWM_DUTY_CTRL_RAMP_EN
        w_presc_nxt = '0;
`endif
      end
`ifdef PWM_DUTY_CTRL_RAMP_EN
      // Leaving ramp mode wins over a coincident tick.
      c_st_ramp_up: begin
        if (!bus.mode) begin
          w_presc_nxt = '0;
        end else begin
          w_presc_nxt = w_tick ? '0 : r_presc + c_pre_one;
          if (w_tick && r_duty != 4'd15) w_duty_nxt = r_duty + 4'd1;
        end
      end
      c_st_ramp_dn: begin
        if (!bus.mode) begin
          w_presc_nxt = '0;
        end else begin
          w_presc_nxt = w_tick ? '0 : r_presc + c_pre_one;
          if (w_tick && r_duty != 4'd0) w_duty_nxt = r_duty - 4'd1;
        end
      end
`endif
      default: w_duty_nxt = r_duty;
    endcase
  end

  assign bus.duty       = r_duty;
  assign bus.step_pulse = r_step;
  assign bus.at_min     = (r_duty == 4'd0);
  assign bus.at_max     = (r_duty == 4'd15);
`ifdef PWM_DUTY_CTRL_RAMP_EN
  assign bus.ramp_active = (r_state != c_st_manual);
`else
  assign bus.ramp_active = 1'b0;

  logic w_unused_cfg;
  assign w_unused_cfg = bus.mode | (RAMP_DIV > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_duty_ctrl
// Description : Randomized self-checking bench for pwm_duty_ctrl against a
//               behavioural model; ramp scenarios need PWM_DUTY_CTRL_RAMP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_ctrl;

  localparam int D    = 4;
  localparam int RDIV = 3;
`ifdef PWM_DUTY_CTRL_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
`else
  localparam bit RAMP_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  pwm_duty_ctrl_if bus ();

  pwm_duty_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .RAMP_DIV        (RDIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_pass    = 0;
  int pulse_cnt = 0;

  // Model state: raw samples per edge, debounced levels, duty and ramp bookkeeping.
  bit m_hist_up[$];
  bit m_hist_dn[$];
  bit m_deb_up, m_deb_dn, m_pend_up, m_pend_dn;
  int m_k, m_duty, m_entry;
  bit m_step, m_ramp, m_dir_up;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
  endtask

  // Level flips once the synchronized input (raw delayed two edges) has
  // disagreed with it on each of the last D edges.
  function automatic bit win_flip(input bit q[$], input bit deb);
    for (int j = 0; j < D; j++)
      if (q[q.size() - 3 - j] == deb) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_hist_up.delete();
    m_hist_dn.delete();
    for (int i = 0; i < D + 2; i++) begin
      m_hist_up.push_back(1'b0);
      m_hist_dn.push_back(1'b0);
    end
    m_deb_up = 0; m_deb_dn = 0; m_pend_up = 0; m_pend_dn = 0;
    m_k = 0; m_duty = 0; m_entry = 0;
    m_step = 0; m_ramp = 0; m_dir_up = 1;
  endtask

  task automatic model_step(input bit up, input bit dn, input bit md);
    bit ev_up, ev_dn;
    int old;
    ev_up = m_pend_up;
    ev_dn = m_pend_dn;
    m_pend_up = 0;
    m_pend_dn = 0;
    old = m_duty;
    m_hist_up.push_back(up); void'(m_hist_up.pop_front());
    m_hist_dn.push_back(dn); void'(m_hist_dn.pop_front());
    if (win_flip(m_hist_up, m_deb_up)) begin m_deb_up = !m_deb_up; m_pend_up = m_deb_up; end
    if (win_flip(m_hist_dn, m_deb_dn)) begin m_deb_dn = !m_deb_dn; m_pend_dn = m_deb_dn; end
    if (!m_ramp) begin
      if (ev_up && !ev_dn)      m_duty = (m_duty < 15) ? m_duty + 1 : 15;
      else if (ev_dn && !ev_up) m_duty = (m_duty > 0) ? m_duty - 1 : 0;
      if (RAMP_EN && md) begin
        m_ramp   = 1;
        m_dir_up = (old != 15);
        m_entry  = m_k;
      end
    end else if (!md) begin
      m_ramp = 0;
    end else if ((m_k - m_entry) % RDIV == 0) begin
      if (m_dir_up) begin
        m_duty = m_duty + 1;
        if (m_duty == 15) m_dir_up = 0;
      end else begin
        m_duty = m_duty - 1;
        if (m_duty == 0) m_dir_up = 1;
      end
    end
    m_step = (m_duty != old);
    m_k++;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step(bus.btn_up, bus.btn_dn, bus.mode);
    #1;
    if (bus.step_pulse) pulse_cnt++;
    check_val("duty",        bus.duty,        m_duty);
    check_val("step_pulse",  bus.step_pulse,  m_step);
    check_val("at_min",      bus.at_min,      m_duty == 0);
    check_val("at_max",      bus.at_max,      m_duty == 15);
    check_val("ramp_active", bus.ramp_active, m_ramp);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic seg(input bit up, input bit dn, input int hold, input int gap);
    bus.btn_up = up;
    bus.btn_dn = dn;
    run(hold);
    bus.btn_up = 0;
    bus.btn_dn = 0;
    run(gap);
  endtask

  // Edge index (0 = first edge sampling the held button) at which duty first
  // reaches the target; -1 if it never does within the bound.
  task automatic measure_latency(input int target, output int lat);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (lat < 0 && bus.duty == 4'(target)) lat = i;
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_duty"},  bus.duty,        0);
    check_val({pfx, "_min"},   bus.at_min,      1);
    check_val({pfx, "_max"},   bus.at_max,      0);
    check_val({pfx, "_step"},  bus.step_pulse,  0);
    check_val({pfx, "_ramp"},  bus.ramp_active, 0);
  endtask

  initial begin
    int lat;
    bus.btn_up = 0;
    bus.btn_dn = 0;
    bus.mode   = 0;
    model_reset();

    #2 rst_n = 0;
    #1 check_reset_outputs("reset");
    run(3);
    @(negedge clk) rst_n = 1;

    // Single held press: one step at edge 2+D, nothing more while held.
    pulse_cnt  = 0;
    bus.btn_up = 1;
    measure_latency(1, lat);
    check_val("press_latency", lat, 2 + D);
    check_val("held_pulses", pulse_cnt, 1);
    check_val("held_duty", bus.duty, 1);
    bus.btn_up = 0;
    run(8);

    // Short and bouncing pulses are filtered.
    seg(1, 0, 3, 8);
    check_val("glitch_up3", bus.duty, 1);
    seg(0, 1, 2, 8);
    check_val("glitch_dn2", bus.duty, 1);
    seg(1, 0, 1, 1);
    seg(1, 0, 1, 8);
    check_val("glitch_bounce", bus.duty, 1);

    for (int i = 0; i < 16; i++) begin
      pulse_cnt = 0;
      seg(1, 0, 6, 6);
    end
    check_val("sat_up_last_pulse", pulse_cnt, 0);
    check_val("sat_up_duty", bus.duty, 15);
    check_val("sat_up_at_max", bus.at_max, 1);
    seg(1, 1, 6, 6);
    check_val("both_duty", bus.duty, 15);
    for (int i = 0; i < 16; i++) seg(0, 1, 6, 6);
    check_val("sat_dn_duty", bus.duty, 0);
    check_val("sat_dn_at_min", bus.at_min, 1);

`ifdef PWM_DUTY_CTRL_RAMP_EN
    for (int i = 0; i < 14; i++) seg(1, 0, 6, 6);
    check_val("pre_ramp_duty", bus.duty, 14);
    bus.mode = 1;
    run(1 + RDIV);
    check_val("ramp_first_step", bus.duty, 15);
    run(RDIV);
    check_val("ramp_second_step", bus.duty, 14);
    run(RDIV * 16 + 5);
    check_val("ramp_active_on", bus.ramp_active, 1);
    bus.mode = 0;
    run(8);
    check_val("ramp_exit", bus.ramp_active, 0);
    seg(1, 0, 6, 6);
    seg(0, 1, 6, 6);
`else
    bus.mode = 1;
    run(20);
    check_val("noramp_active", bus.ramp_active, 0);
    check_val("noramp_duty", bus.duty, 0);
    bus.mode = 0;
`endif

    // Reset three cycles into a debounce, release with the button held.
    seg(1, 0, 6, 6);
    bus.btn_up = 1;
    run(3);
    #2 rst_n = 0;
    #1 check_reset_outputs("midrst");
    model_reset();
    run(2);
    @(negedge clk) rst_n = 1;
    measure_latency(1, lat);
    check_val("rst_release_latency", lat, 2 + D);
    bus.btn_up = 0;
    run(8);

    for (int i = 0; i < 60; i++) begin
      if (RAMP_EN) bus.mode = ($urandom_range(0, 5) == 0);
      seg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom_range(1, 8), $urandom_range(0, 8));
    end
    bus.mode = 0;
    run(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
